// File: rtl/psum_line_buffer.sv
// psum_line_buffer: programmable-length delay line for the signed partial-sum
// stream leaving one convolution row. Samples are held in a circular RAM and
// each is replayed exactly line_len accepted samples after it was pushed.
module psum_line_buffer #(
  parameter int SUM_BW = 16,
  parameter int DEPTH  = 8,
  parameter int LEN_BW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic [LEN_BW-1:0] i_line_len,
  input  logic              i_valid,
  input  logic [SUM_BW-1:0] i_psum,
  output logic [SUM_BW-1:0] o_psum,
  output logic              o_valid,
  output logic              o_primed,
  output logic              o_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_BW-1:0] DEPTH_L  = LEN_BW'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  // Advance a circular pointer, wrapping from DEPTH-1 back to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == LAST_PTR) begin
      r = {PTR_W{1'b0}};
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [LEN_BW-1:0] len_q, len_d;
  logic [LEN_BW-1:0] count_q, count_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [SUM_BW-1:0] o_psum_q, o_psum_d;
  logic              o_valid_q, o_valid_d;
  logic              o_primed_q, o_primed_d;
  logic              o_err_q, o_err_d;
  logic              len_legal_s;
  logic              mem_we_s;
  logic [LEN_BW-1:0] count_inc_s;
  logic [SUM_BW-1:0] mem_q [DEPTH];

  // Next-state logic: clear has priority over push; reads see the old RAM entry.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    o_psum_d    = o_psum_q;
    o_valid_d   = 1'b0;
    o_err_d     = o_err_q;
    mem_we_s    = 1'b0;
    len_legal_s = (i_line_len != {LEN_BW{1'b0}}) && (i_line_len <= DEPTH_L);
    count_inc_s = count_q + LEN_BW'(1);

    if (i_clear) begin
      count_d = {LEN_BW{1'b0}};
      wr_d    = {PTR_W{1'b0}};
      rd_d    = {PTR_W{1'b0}};
      if (len_legal_s) begin
        len_d   = i_line_len;
        o_err_d = 1'b0;
        state_d = ST_FILL;
      end else begin
        o_err_d = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (i_valid) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_FILL: begin
          mem_we_s = 1'b1;
          wr_d     = ptr_inc(wr_q);
          count_d  = count_inc_s;
          if (count_inc_s == len_q) begin
            state_d = ST_STREAM;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_STREAM: begin
          // rd trails wr by len; when len==DEPTH they coincide and the
          // combinational read still returns the entry about to be replaced.
          mem_we_s  = 1'b1;
          o_psum_d  = mem_q[rd_q];
          o_valid_d = 1'b1;
          wr_d      = ptr_inc(wr_q);
          rd_d      = ptr_inc(rd_q);
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    o_primed_d = (state_d == ST_STREAM);
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= {LEN_BW{1'b0}};
      count_q    <= {LEN_BW{1'b0}};
      wr_q       <= {PTR_W{1'b0}};
      rd_q       <= {PTR_W{1'b0}};
      o_psum_q   <= {SUM_BW{1'b0}};
      o_valid_q  <= 1'b0;
      o_primed_q <= 1'b0;
      o_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      o_psum_q   <= o_psum_d;
      o_valid_q  <= o_valid_d;
      o_primed_q <= o_primed_d;
      o_err_q    <= o_err_d;
    end
  end

  // Sample storage; contents are meaningless until written after a clear.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_q] <= i_psum;
    end
  end

  assign o_psum   = o_psum_q;
  assign o_valid  = o_valid_q;
  assign o_primed = o_primed_q;
  assign o_err    = o_err_q;

endmodule
